// File: rtl/up_down_mod_counter_pkg.sv
// counter_pkg: shared constants and helpers for up_down_mod_counter.
//   dir_e  : DIR_UP / DIR_DOWN encoding of the dir input
//   mode_e : MODE_WRAP / MODE_SAT encoding of the sat_mode input
//   clog2  : bit width needed to hold 0..value-1 (prescaler sizing)
// Optional feature macro: UDC_PRESCALE_EN (see up_down_mod_counter.sv).
package counter_pkg;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } mode_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned v;
      int unsigned r;
      r = 0;
      v = (value > 0) ? value - 1 : 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/up_down_mod_counter_if.sv
// up_down_mod_counter_if: control/data bundle of the up/down modulus counter.
//   en, dir, sat_mode, load, load_val : controls driven by the master
//   q, tc, sat_hit                    : counter state and pulses driven by the slave
// Modports: master (user of the counter), slave (the counter itself).
interface up_down_mod_counter_if #(
   parameter int unsigned WIDTH = 4
);
   logic             en;
   logic             dir;
   logic             sat_mode;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             sat_hit;

   modport master (
      output en, dir, sat_mode, load, load_val,
      input  q, tc, sat_hit
   );

   modport slave (
      input  en, dir, sat_mode, load, load_val,
      output q, tc, sat_hit
   );
endinterface

// File: rtl/up_down_mod_counter_prescaler.sv
// udc_prescaler: divides count-enable cycles by PRESCALE.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   en   : advance the phase counter (holds when low)
//   clr  : synchronous clear of the phase (used on load)
//   tick : high on the enabled cycle where the phase equals PRESCALE-1
// Only instantiated when UDC_PRESCALE_EN is defined.
module udc_prescaler
   import counter_pkg::*;
#(
   parameter int unsigned PRESCALE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned    PW   = clog2(PRESCALE);
   localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] r_cnt;
   logic          w_last;

   assign w_last = (r_cnt == LAST);
   assign tick   = en & w_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= w_last ? '0 : r_cnt + PW'(1);
      end
   end

endmodule

// File: rtl/up_down_mod_counter.sv
// up_down_mod_counter: synchronous parametrised up/down modulus counter.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : up_down_mod_counter_if.slave
//          en/dir/sat_mode/load/load_val in; q (count), tc (wrap pulse),
//          sat_hit (blocked-step pulse) out, all registered
// Priority per edge: rst > load > step, step = en & tick.
// Optional feature macro: UDC_PRESCALE_EN -- when defined, a step only
// happens every PRESCALE enabled cycles; otherwise tick is constant 1.
module up_down_mod_counter
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned MODULUS  = 16,
   parameter int unsigned PRESCALE = 4
) (
   input logic                       clk,
   input logic                       rst,
   up_down_mod_counter_if.slave      bus
);

   localparam logic [WIDTH-1:0] MAX    = WIDTH'(MODULUS - 1);
   // One extra bit so MODULUS == 2**WIDTH is representable.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0] r_q;
   logic             r_tc;
   logic             r_sat_hit;

   logic [WIDTH-1:0] w_q_nxt;
   logic             w_tc_nxt;
   logic             w_sat_nxt;
   logic             w_tick;
   logic             w_step;

`ifdef UDC_PRESCALE_EN
   udc_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (bus.en),
      .clr  (bus.load),
      .tick (w_tick)
   );
`else
   assign w_tick = 1'b1;
`endif

   assign w_step = bus.en & w_tick;

   always_comb begin
      w_q_nxt   = r_q;
      w_tc_nxt  = 1'b0;
      w_sat_nxt = 1'b0;
      if (bus.load) begin
         w_q_nxt = ({1'b0, bus.load_val} >= MOD_EXT) ? MAX : bus.load_val;
      end else if (w_step) begin
         if (bus.dir == DIR_UP) begin
            if (r_q == MAX) begin
               if (bus.sat_mode == MODE_SAT) begin
                  w_sat_nxt = 1'b1;
               end else begin
                  w_q_nxt  = '0;
                  w_tc_nxt = 1'b1;
               end
            end else begin
               w_q_nxt = r_q + WIDTH'(1);
            end
         end else begin
            if (r_q == '0) begin
               if (bus.sat_mode == MODE_SAT) begin
                  w_sat_nxt = 1'b1;
               end else begin
                  w_q_nxt  = MAX;
                  w_tc_nxt = 1'b1;
               end
            end else begin
               w_q_nxt = r_q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q       <= '0;
         r_tc      <= 1'b0;
         r_sat_hit <= 1'b0;
      end else begin
         r_q       <= w_q_nxt;
         r_tc      <= w_tc_nxt;
         r_sat_hit <= w_sat_nxt;
      end
   end

   assign bus.q       = r_q;
   assign bus.tc      = r_tc;
   assign bus.sat_hit = r_sat_hit;

endmodule
